// File: rtl/adv_pkg.sv
// Shared adventure-game constants: item slot indices and sizing helpers.
package adv_pkg;

  localparam int ITEM_SWORD  = 0;
  localparam int ITEM_KEY    = 1;
  localparam int ITEM_POTION = 2;
  localparam int ITEM_GEM    = 3;

  localparam int N_ITEMS_DEF = 4;

  // Index width, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inv_slot.sv
// One inventory slot: a saturating up/down counter with optional
// sticky (non-consumable) behaviour.
module inv_slot #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec_req,
  input  logic             sticky,
  output logic [CNT_W-1:0] count,
  output logic             have,
  output logic             full,
  output logic             grant
);

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             dec;

  assign have  = (count_q != '0);
  assign full  = (count_q == MAX);
  assign grant = dec_req & have;
  assign dec   = grant & ~sticky;
  assign count = count_q;

  // Grant uses the pre-edge count; inc and dec together cancel.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec) begin
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (dec && !inc) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/inventory_bank.sv
// Bank of N_ITEMS saturating item counters with edge-detected pickups
// and a one-cycle-latency use request/acknowledge port.
module inventory_bank
  import adv_pkg::*;
#(
  parameter int                 N_ITEMS     = N_ITEMS_DEF,
  parameter int                 CNT_W       = 2,
  parameter logic [N_ITEMS-1:0] STICKY_MASK = N_ITEMS'(1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_ITEMS-1:0]         pick,
  input  logic                       clear_all,
  input  logic                       use_valid,
  input  logic [idx_w(N_ITEMS)-1:0]  use_idx,
  output logic                       use_ack,
  output logic                       use_ok,
  output logic [N_ITEMS-1:0]         have,
  output logic [N_ITEMS-1:0]         full,
  output logic [N_ITEMS*CNT_W-1:0]   count
);

  localparam int IW = idx_w(N_ITEMS);

  logic [N_ITEMS-1:0] pick_q;
  logic [N_ITEMS-1:0] pick_edge;
  logic [N_ITEMS-1:0] dec_req;
  logic [N_ITEMS-1:0] grant;
  logic               ack_q;
  logic               ack_d;
  logic               ok_q;
  logic               ok_d;

  assign pick_edge = pick & ~pick_q;

  // Out-of-range indices select no slot and are therefore denied.
  always_comb begin
    dec_req = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      dec_req[i] = use_valid && (use_idx == IW'(i));
    end
  end

  for (genvar g = 0; g < N_ITEMS; g++) begin : g_slot
    inv_slot #(
      .CNT_W (CNT_W)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .clr     (clear_all),
      .inc     (pick_edge[g]),
      .dec_req (dec_req[g]),
      .sticky  (STICKY_MASK[g]),
      .count   (count[g*CNT_W +: CNT_W]),
      .have    (have[g]),
      .full    (full[g]),
      .grant   (grant[g])
    );
  end

  assign ack_d = use_valid;
  assign ok_d  = use_valid & (|grant) & ~clear_all;

  always_ff @(posedge clk) begin
    if (reset) begin
      pick_q <= '0;
      ack_q  <= 1'b0;
      ok_q   <= 1'b0;
    end else begin
      pick_q <= pick;
      ack_q  <= ack_d;
      ok_q   <= ok_d;
    end
  end

  assign use_ack = ack_q;
  assign use_ok  = ok_q;

endmodule
